coin_game_ctrl: RTL
===================

Name: coin_game_ctrl

Overview:
Round controller for the coin-collection game: it sequences one timed round of play around the coin display/relocation block. It gates the coin (coin_en), counts single-cycle reach_coin pulses into a BCD score, and runs a one-second BCD countdown. It ends the round as WIN (target reached) or LOSE (time expired). Outputs feed the HUD digit renderer and the top-level game-state mux.

Parameters:
TICK_CYCLES, 25000000, clk cycles per game second (25 MHz pixel clock); legal range 2..2^25.
GAME_SECONDS, 60, round length in seconds; legal range 1..99.
TARGET_COINS, 20, coins needed to win; legal range 1..99.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle start/restart pulse (debounced button)
reach_coin  in  1  single-cycle pulse, one per coin collected
coin_en  out  1  high only in PLAY; enables coin drawing/collision
state  out  2  0=IDLE, 1=PLAY, 2=WIN, 3=LOSE
score_tens  out  4  BCD tens digit of score
score_ones  out  4  BCD ones digit of score
time_tens  out  4  BCD tens digit of remaining seconds
time_ones  out  4  BCD ones digit of remaining seconds
sec_tick  out  1  one-cycle pulse per elapsed game second in PLAY
game_over  out  1  high in WIN or LOSE
win  out  1  high in WIN only

Behaviour:
- Reset (async, any time, including mid-round): state=IDLE, score=00, time=GAME_SECONDS as BCD, prescaler=0, sec_tick=0, coin_en=0, game_over=0, win=0.
- All outputs registered or decoded from registered state; no combinational path from inputs to outputs.
- IDLE: score=00 and time=GAME_SECONDS held. start -> PLAY on the next edge, prescaler cleared.
- PLAY: the prescaler counts 0..TICK_CYCLES-1 and wraps. On the cycle the prescaler reaches TICK_CYCLES-1, sec_tick=1 (registered, visible the following cycle) and time decrements by one in BCD. Ones borrow: 0->9 with tens-1.
- First sec_tick occurs TICK_CYCLES cycles after entering PLAY.
- reach_coin in PLAY: score increments by one in BCD (ones 9->0 with carry into tens); the score saturates at 99.
- reach_coin in IDLE/WIN/LOSE is ignored.
- Transition priority is evaluated each PLAY cycle, using post-update values:
  - score == TARGET_COINS -> WIN.
  - else time == 00 -> LOSE.
  - A coin that lands on the same cycle as the final second's tick is counted; if it reaches the target, WIN wins over LOSE.
- start asserted during PLAY is ignored. reach_coin and start asserted in the same IDLE cycle: start is taken, the coin is ignored.
- WIN/LOSE: score and time freeze, coin_en=0, prescaler held at 0, game_over=1, win=(state==WIN). start -> PLAY on the next edge, with score=00, time=GAME_SECONDS, prescaler=0.
- Back-to-back reach_coin pulses on consecutive cycles each count. The upstream edge detect guarantees at most one pulse per cycle.
- Widths: prescaler ceil(log2(TICK_CYCLES)) bits; all digit registers 4 bits and never outside 0..9.

Test Plan (bench overrides TICK_CYCLES=4, GAME_SECONDS=3, TARGET_COINS=12):
- Assert rst mid-round (state=PLAY, score=05, time=02) -> outputs immediately IDLE, score 0/0, time 0/3, coin_en=0; they hold after release until start.
- Pulse start, no coins -> PLAY with coin_en=1; sec_tick every 4 cycles; time goes 3,2,1,0; state=LOSE the cycle after time=00; game_over=1, win=0, coin_en=0.
- In PLAY, issue 12 reach_coin pulses on consecutive cycles -> score shows 09 then 10 (ones carry), reaches 12; state=WIN on the next edge; further pulses leave score=12.
- Place the 12th reach_coin on the same cycle as the tick that makes time 00 -> state=WIN, not LOSE; score=12, time=00.
- Pulse reach_coin in IDLE and in LOSE -> score unchanged. Pulse start in LOSE -> PLAY with score=00, time=03; the first sec_tick comes exactly 4 cycles later.
- Run with TARGET_COINS=99 and 105 pulses -> score saturates at 9/9 and never shows a non-BCD nibble.

Source files
------------

// File: rtl/coin_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coin_game_ctrl
// Description : Round controller for the coin-collection game. Gates the coin,
//               keeps a saturating BCD score, runs a one-second BCD countdown
//               and ends the round as WIN (target reached) or LOSE (time out).
// Revision    : 1.0 - initial release
// ============================================================================
module coin_game_ctrl #(
    parameter int TICK_CYCLES  = 25000000,
    parameter int GAME_SECONDS = 60,
    parameter int TARGET_COINS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       reach_coin,
    output logic       coin_en,
    output logic [1:0] state,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       sec_tick,
    output logic       game_over,
    output logic       win
);

    localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    TIME_T0   = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    TIME_O0   = 4'(GAME_SECONDS % 10);
    localparam logic [3:0]    TGT_T     = 4'(TARGET_COINS / 10);
    localparam logic [3:0]    TGT_O     = 4'(TARGET_COINS % 10);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    state_t        cur_state, nxt_state;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    sc_t, sc_o, tm_t, tm_o;
    logic [3:0]    sc_t_nxt, sc_o_nxt, tm_t_nxt, tm_o_nxt;
    logic          tick_nxt;
    logic          score_hit, time_up, tick_now, score_max;

    // Round-end conditions look at the registered (already updated) counters,
    // so a coin landing with the final tick is counted before the decision.
    assign score_hit = (sc_t == TGT_T) && (sc_o == TGT_O);
    assign time_up   = (tm_t == 4'd0) && (tm_o == 4'd0);
    assign tick_now  = (presc == TICK_LAST);
    assign score_max = (sc_t == 4'd9) && (sc_o == 4'd9);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and datapath next values: prescaler, BCD countdown, BCD score.
    always_comb begin
        nxt_state = cur_state;
        presc_nxt = presc;
        sc_t_nxt  = sc_t;
        sc_o_nxt  = sc_o;
        tm_t_nxt  = tm_t;
        tm_o_nxt  = tm_o;
        tick_nxt  = 1'b0;
        case (cur_state)
            ST_PLAY: begin
                if (score_hit) begin
                    nxt_state = ST_WIN;
                    presc_nxt = '0;
                end else if (time_up) begin
                    nxt_state = ST_LOSE;
                    presc_nxt = '0;
                end else begin
                    if (tick_now) begin
                        presc_nxt = '0;
                        tick_nxt  = 1'b1;
                        // Time is known non-zero here, so the borrow never underflows.
                        if (tm_o == 4'd0) begin
                            tm_o_nxt = 4'd9;
                            tm_t_nxt = tm_t - 4'd1;
                        end else begin
                            tm_o_nxt = tm_o - 4'd1;
                        end
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                    if (reach_coin && !score_max) begin
                        if (sc_o == 4'd9) begin
                            sc_o_nxt = 4'd0;
                            sc_t_nxt = sc_t + 4'd1;
                        end else begin
                            sc_o_nxt = sc_o + 4'd1;
                        end
                    end
                end
            end
            default: begin
                // IDLE, WIN and LOSE all restart the round on start; coins ignored.
                presc_nxt = '0;
                if (start) begin
                    nxt_state = ST_PLAY;
                    sc_t_nxt  = 4'd0;
                    sc_o_nxt  = 4'd0;
                    tm_t_nxt  = TIME_T0;
                    tm_o_nxt  = TIME_O0;
                end
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            sc_t     <= 4'd0;
            sc_o     <= 4'd0;
            tm_t     <= TIME_T0;
            tm_o     <= TIME_O0;
            sec_tick <= 1'b0;
        end else begin
            presc    <= presc_nxt;
            sc_t     <= sc_t_nxt;
            sc_o     <= sc_o_nxt;
            tm_t     <= tm_t_nxt;
            tm_o     <= tm_o_nxt;
            sec_tick <= tick_nxt;
        end
    end

    assign state      = cur_state;
    assign coin_en    = (cur_state == ST_PLAY);
    assign game_over  = (cur_state == ST_WIN) || (cur_state == ST_LOSE);
    assign win        = (cur_state == ST_WIN);
    assign score_tens = sc_t;
    assign score_ones = sc_o;
    assign time_tens  = tm_t;
    assign time_ones  = tm_o;

endmodule
`default_nettype wire
